axis_extremum_tracker: RTL and testbench
========================================

// Module: axis_extremum_tracker
// PURPOSE
//  Multi-channel successor of the single-channel extremum finder. Collects per-channel min/max
//  over a window of 2^EF_log_count accepted AXIS beats. Emits hysteresis thresholds per channel,
//  shrunk toward the window centre by EF_shift, plus a window-done pulse.
//  Sits after the ADC/filter stream; thresholds feed the fringe counter / comparator stage.
// PARAMETERS
//  CHANNEL_WIDTH  16  signed sample width per channel
//  CHANNELS       2   channels packed in tdata, ch0 in LSBs
//  COUNT_WIDTH    5   width of EF_log_count (window max 2^(2^COUNT_WIDTH-1) beats)
// PORTS
//  aclk                clk in  1                  clock
//  aresetn             in  1                      async active-low reset
//  EF_enable           in  1                      0: hold thresholds, abort window, tready=0
//  EF_log_count        in  COUNT_WIDTH            log2 window length, sampled at window start
//  EF_shift            in  3                      threshold shrink (arith. shift), sampled at UPDATE
//  EF_lower_threshold  out CHANNELS*CHANNEL_WIDTH per-channel lower threshold, signed
//  EF_upper_threshold  out CHANNELS*CHANNEL_WIDTH per-channel upper threshold, signed
//  EF_done             out 1                      1-cycle pulse when thresholds update
//  S_AXIS_tvalid       in  1                      slave valid
//  S_AXIS_tdata        in  CHANNELS*CHANNEL_WIDTH packed samples
//  S_AXIS_tready       out 1                      slave ready
// BEHAVIOUR
//  Reset (async, aresetn=0): lower=+max (0111..), upper=-max (1000..) per channel, EF_done=0,
//   tready=0, state=IDLE, count=0, tmp_min=+max, tmp_max=-max.
//  FSM IDLE -> MEASURE -> UPDATE -> MEASURE ...
//   IDLE: tready=0; load tmp_min=+max, tmp_max=-max, count=0, latch EF_log_count;
//    go MEASURE next cycle if EF_enable=1.
//   MEASURE: tready=1. Only beats with tvalid&tready count; idle cycles do not advance count.
//    Per beat, per channel: signed compare, update tmp_min/tmp_max.
//    Beat with count==2^log_count-1 includes its sample, then -> UPDATE.
//   UPDATE (exactly 1 cycle, tready=0): per channel, in CHANNEL_WIDTH+1 bits:
//    c = (tmp_max+tmp_min)>>>1; lower = c+((tmp_min-c)>>>EF_shift);
//    upper = c+((tmp_max-c)>>>EF_shift); truncate to CHANNEL_WIDTH (always in range).
//    Outputs registered; visible and EF_done=1 the cycle after UPDATE.
//    Same edge: tmp reset to extremes, count=0, log_count re-latched, -> MEASURE.
//  Latency: last window beat accepted at cycle N -> thresholds/EF_done valid at N+2.
//  Throughput: window of W beats takes >= W+1 cycles (one UPDATE bubble).
//  log_count=0: every beat is a 1-beat window; lower=upper=sample (any shift).
//  Equal samples, or min==max: lower=upper=that value.
//  EF_enable falling in any state -> IDLE next cycle. Partial window discarded, outputs held,
//   no EF_done. Re-enable starts a fresh window.
//  count is 32-bit; log_count>31 saturates to 31.
//  aresetn mid-window: immediate return to reset values, no EF_done.
// CONFIGURATION
//  EF_SMOOTH_EN defined: adds input EF_alpha[2:0]; in UPDATE each output moves
//   out <= out + ((new-out)>>>EF_alpha), CHANNEL_WIDTH+1 arithmetic. Exception: first update
//   after reset/re-enable loads new directly. EF_alpha=0 equals unsmoothed behaviour.
//  Undefined: no EF_alpha port; outputs load computed values directly.
// TESTING
//  1) CHANNELS=2, log=2, shift=0, ch0 {-100,50,20,-10}, ch1 {5,5,5,5} -> ch0 lower=-100,
//     upper=50; ch1 lower=upper=5; EF_done 2 cycles after 4th beat.
//  2) Same ch0 data, shift=1 -> c=-25, lower=-63 (-25+(-75>>>1)), upper=12; check rounding.
//  3) tvalid gapped 1-of-3 cycles, log=3 -> done only after 8 accepted beats;
//     tready=0 in UPDATE cycle.
//  4) log=0 stream {7,-3} -> two EF_done pulses; thresholds 7/7 then -3/-3.
//  5) EF_enable low mid-window (after 3 of 8 beats) -> no EF_done, outputs held; re-enable ->
//     next done after 8 new beats. Repeat with aresetn pulse -> reset values.
//  6) EF_SMOOTH_EN, alpha=1: first window upper=100, second window computed 0 -> upper=50.

Source files
------------

// File: rtl/axis_extremum_tracker.sv
// Per-channel windowed min/max tracker on an AXI-Stream input, producing shrunk hysteresis
// thresholds and a done pulse per window. Optional smoothing of outputs via EF_SMOOTH_EN.
module axis_extremum_tracker #(
  parameter int unsigned CHANNEL_WIDTH = 16,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned COUNT_WIDTH   = 5
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              EF_enable,
  input  logic [COUNT_WIDTH-1:0]            EF_log_count,
  input  logic [2:0]                        EF_shift,
`ifdef EF_SMOOTH_EN
  input  logic [2:0]                        EF_alpha,
`endif
  output logic [CHANNELS*CHANNEL_WIDTH-1:0] EF_lower_threshold,
  output logic [CHANNELS*CHANNEL_WIDTH-1:0] EF_upper_threshold,
  output logic                              EF_done,
  input  logic                              S_AXIS_tvalid,
  input  logic [CHANNELS*CHANNEL_WIDTH-1:0] S_AXIS_tdata,
  output logic                              S_AXIS_tready
);

  localparam int unsigned W = CHANNEL_WIDTH;
  localparam logic [W-1:0] PosMax = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NegMax = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMeasure, StUpdate} state_e;

  state_e      state_q;
  logic [31:0] count_q;
  logic [4:0]  log_q;
  logic        done_q;
  logic [W-1:0] min_q   [CHANNELS];
  logic [W-1:0] max_q   [CHANNELS];
  logic [W-1:0] lower_q [CHANNELS];
  logic [W-1:0] upper_q [CHANNELS];
  logic [W-1:0] lower_new [CHANNELS];
  logic [W-1:0] upper_new [CHANNELS];
`ifdef EF_SMOOTH_EN
  logic        first_q;
`endif

  logic        beat;
  logic        last_beat;
  logic [31:0] log_ext;
  logic [4:0]  log_sat;

  assign S_AXIS_tready = (state_q == StMeasure) && EF_enable;
  assign beat          = S_AXIS_tvalid && S_AXIS_tready;
  assign last_beat     = (count_q == ((32'd1 << log_q) - 32'd1));
  assign log_ext       = 32'(EF_log_count);
  assign log_sat       = (log_ext > 32'd31) ? 5'd31 : log_ext[4:0];
  assign EF_done       = done_q;

  // c + ((ext - c) >>> sh) with c the window centre, all in W+1 bits.
  function automatic logic [W-1:0] shrink(input logic [W-1:0] mn, input logic [W-1:0] mx,
                                          input logic [W-1:0] ext, input logic [2:0] sh);
    logic signed [W:0] wmn, wmx, wex, c;
    wmn = {mn[W-1], mn};
    wmx = {mx[W-1], mx};
    wex = {ext[W-1], ext};
    c   = (wmn + wmx) >>> 1;
    return W'(c + ((wex - c) >>> sh));
  endfunction

`ifdef EF_SMOOTH_EN
  function automatic logic [W-1:0] blend(input logic [W-1:0] old, input logic [W-1:0] nw,
                                         input logic [2:0] alpha);
    logic signed [W:0] wo, wn;
    wo = {old[W-1], old};
    wn = {nw[W-1], nw};
    return W'(wo + ((wn - wo) >>> alpha));
  endfunction
`endif

  always_comb begin
    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      lower_new[ch] = shrink(min_q[ch], max_q[ch], min_q[ch], EF_shift);
      upper_new[ch] = shrink(min_q[ch], max_q[ch], max_q[ch], EF_shift);
`ifdef EF_SMOOTH_EN
      if (!first_q) begin
        lower_new[ch] = blend(lower_q[ch], lower_new[ch], EF_alpha);
        upper_new[ch] = blend(upper_q[ch], upper_new[ch], EF_alpha);
      end
`endif
      EF_lower_threshold[ch*W +: W] = lower_q[ch];
      EF_upper_threshold[ch*W +: W] = upper_q[ch];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      count_q <= '0;
      log_q   <= '0;
      done_q  <= 1'b0;
`ifdef EF_SMOOTH_EN
      first_q <= 1'b1;
`endif
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
        min_q[ch]   <= PosMax;
        max_q[ch]   <= NegMax;
        lower_q[ch] <= PosMax;
        upper_q[ch] <= NegMax;
      end
    end else begin
      done_q <= 1'b0;
      if (!EF_enable) begin
        // Partial window is dropped; thresholds hold their last value.
        state_q <= StIdle;
        count_q <= '0;
`ifdef EF_SMOOTH_EN
        first_q <= 1'b1;
`endif
        for (int ch = 0; ch < int'(CHANNELS); ch++) begin
          min_q[ch] <= PosMax;
          max_q[ch] <= NegMax;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            count_q <= '0;
            log_q   <= log_sat;
            state_q <= StMeasure;
            for (int ch = 0; ch < int'(CHANNELS); ch++) begin
              min_q[ch] <= PosMax;
              max_q[ch] <= NegMax;
            end
          end
          StMeasure: begin
            if (beat) begin
              for (int ch = 0; ch < int'(CHANNELS); ch++) begin
                if ($signed(S_AXIS_tdata[ch*W +: W]) < $signed(min_q[ch])) begin
                  min_q[ch] <= S_AXIS_tdata[ch*W +: W];
                end
                if ($signed(S_AXIS_tdata[ch*W +: W]) > $signed(max_q[ch])) begin
                  max_q[ch] <= S_AXIS_tdata[ch*W +: W];
                end
              end
              count_q <= count_q + 32'd1;
              if (last_beat) state_q <= StUpdate;
            end
          end
          StUpdate: begin
            done_q  <= 1'b1;
            count_q <= '0;
            log_q   <= log_sat;
            state_q <= StMeasure;
`ifdef EF_SMOOTH_EN
            first_q <= 1'b0;
`endif
            for (int ch = 0; ch < int'(CHANNELS); ch++) begin
              lower_q[ch] <= lower_new[ch];
              upper_q[ch] <= upper_new[ch];
              min_q[ch]   <= PosMax;
              max_q[ch]   <= NegMax;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_extremum_tracker.sv
// Directed self-checking bench for axis_extremum_tracker (2 channels x 16 bits).
module tb_axis_extremum_tracker;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        EF_enable = 1'b0;
  logic [4:0]  EF_log_count = '0;
  logic [2:0]  EF_shift = '0;
`ifdef EF_SMOOTH_EN
  logic [2:0]  EF_alpha = '0;
`endif
  logic [31:0] lower, upper;
  logic        done;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = '0;
  logic        tready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axis_extremum_tracker #(
    .CHANNEL_WIDTH(16),
    .CHANNELS     (2),
    .COUNT_WIDTH  (5)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .EF_enable         (EF_enable),
    .EF_log_count      (EF_log_count),
    .EF_shift          (EF_shift),
`ifdef EF_SMOOTH_EN
    .EF_alpha          (EF_alpha),
`endif
    .EF_lower_threshold(lower),
    .EF_upper_threshold(upper),
    .EF_done           (done),
    .S_AXIS_tvalid     (tvalid),
    .S_AXIS_tdata      (tdata),
    .S_AXIS_tready     (tready)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] lo(input int ch);
    logic signed [15:0] v;
    v = lower[ch*16 +: 16];
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] up(input int ch);
    logic signed [15:0] v;
    v = upper[ch*16 +: 16];
    return 32'(v);
  endfunction

  task automatic check_thr(input string tag, input int l0, input int u0, input int l1,
                           input int u1);
    check({tag, "_lo0"}, lo(0), l0);
    check({tag, "_up0"}, up(0), u0);
    check({tag, "_lo1"}, lo(1), l1);
    check({tag, "_up1"}, up(1), u1);
  endtask

  task automatic check_reset(input string tag);
    check_thr(tag, 32767, -32768, 32767, -32768);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_tready"}, 32'(tready), 0);
  endtask

  // One accepted beat; returns 1 time unit after the accepting edge.
  task automatic send(input int a, input int b);
    int n;
    n = 0;
    @(negedge aclk);
    tdata  = {b[15:0], a[15:0]};
    tvalid = 1'b1;
    while (!tready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 20) check("tready_timeout", 32'(tready), 1);
    @(posedge aclk);
    #1 tvalid = 1'b0;
  endtask

  // Called in the UPDATE cycle right after the last beat of a window.
  task automatic expect_update(input string tag, input int l0, input int u0, input int l1,
                               input int u1);
    check({tag, "_upd_tready"}, 32'(tready), 0);
    check({tag, "_upd_done"}, 32'(done), 0);
    @(posedge aclk);
    #1;
    check({tag, "_done"}, 32'(done), 1);
    check_thr(tag, l0, u0, l1, u1);
    @(posedge aclk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  task automatic restart(input int log_n);
    @(negedge aclk);
    EF_enable = 1'b0;
    repeat (2) @(negedge aclk);
    EF_log_count = log_n[4:0];
    EF_enable    = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    check_reset("reset");
    aresetn      = 1'b1;
    EF_log_count = 5'd2;
    EF_shift     = 3'd0;
    EF_enable    = 1'b1;

    // Basic window, no shrink.
    send(-100, 5); send(50, 5); send(20, 5); send(-10, 5);
    expect_update("t1", -100, 50, 5, 5);

    // Shrink by 1: c=-25, lower=-25+(-75>>>1)=-63, upper=-25+(75>>>1)=12.
    EF_shift = 3'd1;
    send(-100, 5); send(50, 5); send(20, 5); send(-10, 5);
    expect_update("t2", -63, 12, 5, 5);

    // Gapped stream, 8-beat window, shift 2.
    EF_shift = 3'd2;
    restart(3);
    for (int i = 0; i < 8; i++) begin
      send(i + 1, -(i + 1));
      if (i < 7) begin
        check("t3_early_done", 32'(done), 0);
        repeat (2) @(negedge aclk);
      end
    end
    expect_update("t3", 3, 5, -6, -4);

    // One-beat windows.
    EF_shift = 3'd3;
    restart(0);
    send(7, 0);
    expect_update("t4a", 7, 7, 0, 0);
    send(-3, 0);
    expect_update("t4b", -3, -3, 0, 0);

    // Disable mid-window: partial window dropped, outputs held.
    EF_shift = 3'd0;
    restart(3);
    send(1000, 1000); send(-1000, -1000); send(5, 5);
    @(negedge aclk);
    EF_enable = 1'b0;
    repeat (4) begin
      @(negedge aclk);
      check("t5_dis_done", 32'(done), 0);
    end
    check("t5_dis_tready", 32'(tready), 0);
    check_thr("t5_hold", -3, -3, 0, 0);
    EF_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(10 * (i + 1), i);
      if (i < 7) check("t5_early_done", 32'(done), 0);
    end
    expect_update("t5", 10, 80, 0, 7);

    // Asynchronous reset mid-window.
    send(1, 1); send(2, 2); send(3, 3);
    #2 aresetn = 1'b0;
    #1 check_reset("t5_rst");
    @(negedge aclk);
    aresetn = 1'b1;

`ifdef EF_SMOOTH_EN
    EF_alpha = 3'd1;
    restart(0);
    send(100, 100);
    expect_update("t6a", 100, 100, 100, 100);
    send(0, 0);
    expect_update("t6b", 50, 50, 50, 50);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
